vc_rr_arbiter: RTL and testbench

//  Round-robin scheduler that drains four virtual-channel input FIFOs into one shared output FIFO.

---
 rtl/vc_rr_arbiter_pkg.sv | 23 ++
 rtl/vc_rr_arbiter_if.sv | 27 ++
 rtl/vc_rr_arbiter_rr_pick4.sv | 27 ++
 rtl/vc_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_vc_rr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_rr_arbiter_pkg.sv
// Shared types for the VC round-robin arbiter: channel count, VC index type
// and the one-hot FSM state encoding.
package vc_rr_arbiter_pkg;

  localparam int NUM_VC = 4;
  localparam int VC_W   = 2;

  typedef logic [VC_W-1:0] vc_idx_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ARB  = 3'b010,
    S_XFER = 3'b100
  } arb_state_e;

  function automatic logic [NUM_VC-1:0] vc_onehot(input vc_idx_t v);
    logic [NUM_VC-1:0] oh;
    oh    = '0;
    oh[v] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vc_rr_arbiter_if.sv
// Bundle of VC-FIFO read side and output-FIFO write side seen by the arbiter.
// master = arbiter, slave = FIFO environment.
interface vc_rr_arbiter_if #(
  parameter int DATA_W = 10
) ();
  import vc_rr_arbiter_pkg::*;

  logic [NUM_VC-1:0]        fifo_empty;
  logic [NUM_VC-1:0]        pause;
  logic [NUM_VC*DATA_W-1:0] data_in;
  logic                     out_almost_full;
  logic                     out_full;
  logic [NUM_VC-1:0]        pop;
  logic                     push;
  logic [DATA_W-1:0]        data_out;

  modport master (
    input  fifo_empty, pause, data_in, out_almost_full, out_full,
    output pop, push, data_out
  );

  modport slave (
    output fifo_empty, pause, data_in, out_almost_full, out_full,
    input  pop, push, data_out
  );

endinterface

// File: rtl/vc_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first eligible VC after last_grant, wrapping 3->0.
module rr_pick4
  import vc_rr_arbiter_pkg::*;
(
  input  logic [NUM_VC-1:0] eligible,
  input  vc_idx_t           last_grant,
  output vc_idx_t           grant,
  output logic              any
);

  vc_idx_t idx;

  always_comb begin
    grant = last_grant;
    any   = 1'b0;
    idx   = last_grant;
    // Offset NUM_VC wraps back onto last_grant itself, so it is checked last.
    for (int k = 1; k <= NUM_VC; k++) begin
      idx = last_grant + VC_W'(k);
      if (!any && eligible[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Round-robin burst scheduler draining four VC FIFOs into one output FIFO.
// Optional per-VC grant counters when ARB_GRANT_CNT_EN is defined.
module vc_rr_arbiter
  import vc_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int MAX_BURST = 4
`ifdef ARB_GRANT_CNT_EN
  ,
  parameter int CNT_W     = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  vc_rr_arbiter_if.master   bus,
  output logic [VC_W-1:0]   active_vc,
  output logic              idle,
  output logic              error
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [NUM_VC*CNT_W-1:0] grant_cnt
`endif
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  arb_state_e        state_q, state_d;
  vc_idx_t           active_vc_q, active_vc_d;
  vc_idx_t           last_grant_q, last_grant_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] pop_d;
  logic              grant_stb;
  vc_idx_t           pick_grant;
  logic              pick_any;

  logic              vld_p0_q, vld_p0_d;
  vc_idx_t           vc_p0_q, vc_p0_d;
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic              error_q, error_d;

  assign eligible = ~bus.fifo_empty & ~bus.pause;

  rr_pick4 u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    active_vc_d  = active_vc_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    pop_d        = '0;
    grant_stb    = 1'b0;
    if (init) begin
      state_d      = S_IDLE;
      active_vc_d  = '0;
      last_grant_d = vc_idx_t'(NUM_VC - 1);
      burst_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|eligible && !bus.out_almost_full) state_d = S_ARB;
        end
        S_ARB: begin
          if (pick_any) begin
            active_vc_d  = pick_grant;
            last_grant_d = pick_grant;
            burst_cnt_d  = '0;
            grant_stb    = 1'b1;
            state_d      = S_XFER;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_XFER: begin
          // Almost-full only stalls; losing eligibility gives up the grant.
          if (!eligible[active_vc_q]) begin
            state_d = S_ARB;
          end else if (!bus.out_almost_full) begin
            pop_d       = vc_onehot(active_vc_q);
            burst_cnt_d = burst_cnt_q + 4'd1;
            if (burst_cnt_d >= MAX_B) state_d = S_ARB;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stage p0: popped VC index travels while the FIFO returns its word.
  // Stage p1: word registered onto data_out together with push.
  always_comb begin
    vld_p0_d  = |pop_d;
    vc_p0_d   = active_vc_q;
    vld_p1_d  = vld_p0_q;
    data_p1_d = vld_p0_q ? bus.data_in[int'(vc_p0_q)*DATA_W +: DATA_W] : data_p1_q;
    error_d   = error_q | (vld_p1_q & bus.out_full);
    if (init) begin
      vld_p0_d = 1'b0;
      vld_p1_d = 1'b0;
      error_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      active_vc_q  <= '0;
      last_grant_q <= vc_idx_t'(NUM_VC - 1);
      burst_cnt_q  <= '0;
      vld_p0_q     <= 1'b0;
      vc_p0_q      <= '0;
      vld_p1_q     <= 1'b0;
      data_p1_q    <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_vc_q  <= active_vc_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      vld_p0_q     <= vld_p0_d;
      vc_p0_q      <= vc_p0_d;
      vld_p1_q     <= vld_p1_d;
      data_p1_q    <= data_p1_d;
      error_q      <= error_d;
    end
  end

  assign bus.pop      = pop_d;
  assign bus.push     = vld_p1_q;
  assign bus.data_out = data_p1_q;
  assign active_vc    = active_vc_q;
  assign idle         = (state_q == S_IDLE) && !vld_p0_q && !vld_p1_q;
  assign error        = error_q;

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] gcnt_q [NUM_VC];
  logic [CNT_W-1:0] gcnt_d [NUM_VC];

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) gcnt_d[i] = gcnt_q[i];
    if (init) begin
      for (int i = 0; i < NUM_VC; i++) gcnt_d[i] = '0;
    end else if (grant_stb && (gcnt_q[pick_grant] != '1)) begin
      gcnt_d[pick_grant] = gcnt_q[pick_grant] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VC; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = gcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Scoreboard bench for vc_rr_arbiter: FIFO model, word-order/latency monitor,
// directed scenarios plus a randomized pause/almost-full phase.
module tb_vc_rr_arbiter;
  import vc_rr_arbiter_pkg::*;

  localparam int DW = 10;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [1:0] active_vc;
  logic       idle;
  logic       error;
`ifdef ARB_GRANT_CNT_EN
  logic [31:0] grant_cnt;
`endif

  vc_rr_arbiter_if #(.DATA_W(DW)) bus ();

  vc_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .bus       (bus.master),
    .active_vc (active_vc),
    .idle      (idle),
    .error     (error)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] w;
    int            c;
  } exp_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [DW-1:0] vcq [4][$];
  logic [7:0]    seq [4];
  exp_t          exp_q [$];
  int            pred_q [$];
  bit            pred_en = 1'b0;
  int            pop_total = 0;
  int            push_total = 0;
  int            last_pop_vc = -1;
  int            cur_vc = -1;
  int            burst_len = 0;
  int            last_burst_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int v, input int n);
    repeat (n) begin
      vcq[v].push_back({2'(v), seq[v]});
      seq[v]++;
    end
  endtask

  // Reference grant order: rotate from the last served VC to the next one
  // holding data, take up to MB words, repeat until everything is gone.
  task automatic build_pred(input int c0, input int c1, input int c2, input int c3,
                            input int start_last);
    int rem [4];
    int last;
    bit found;
    rem[0] = c0; rem[1] = c1; rem[2] = c2; rem[3] = c3;
    last = start_last;
    pred_q.delete();
    do begin
      found = 1'b0;
      for (int k = 1; k <= 4 && !found; k++) begin
        int v;
        v = (last + k) % 4;
        if (rem[v] > 0) begin
          int n;
          n = (rem[v] < MB) ? rem[v] : MB;
          repeat (n) pred_q.push_back(v);
          rem[v] -= n;
          last = v;
          found = 1'b1;
        end
      end
    end while (found);
  endtask

  task automatic wait_drain(input int max, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (idle && exp_q.size() == 0 && vcq[0].size() == 0 && vcq[1].size() == 0 &&
          vcq[2].size() == 0 && vcq[3].size() == 0) ok = 1'b1;
    end
    chk(ok, name, 0, 1);
  endtask

  // FIFO model: pop seen this cycle delivers its word on data_in next cycle.
  initial begin
    logic [3:0] sp;
    bus.fifo_empty = '1;
    bus.data_in    = '0;
    forever begin
      @(negedge clk);
      sp = bus.pop;
      @(posedge clk);
      #1;
      for (int v = 0; v < 4; v++) begin
        if (sp[v] && vcq[v].size() > 0) bus.data_in[v*DW +: DW] = vcq[v].pop_front();
      end
      for (int v = 0; v < 4; v++) bus.fifo_empty[v] = (vcq[v].size() == 0);
    end
  end

  // Monitor: checks every push against the scoreboard, records every pop.
  initial begin
    exp_t e;
    int   v;
    bit   legal;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
      end else begin
        if (bus.push) begin
          push_total++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_push", int'(bus.data_out), -1);
          end else begin
            e = exp_q.pop_front();
            chk(bus.data_out == e.w, "push_data", int'(bus.data_out), int'(e.w));
            chk(cyc == e.c, "push_latency", cyc, e.c);
          end
        end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
          chk(1'b0, "missing_push", cyc, exp_q[0].c);
          void'(exp_q.pop_front());
        end
        if (init) exp_q.delete();
        if (bus.pop != '0) begin
          chk($onehot(bus.pop), "pop_onehot", int'(bus.pop), 1);
          v = 0;
          for (int i = 3; i >= 0; i--) if (bus.pop[i]) v = i;
          legal = !bus.fifo_empty[v] && !bus.pause[v] && !bus.out_almost_full && !init;
          chk(legal, "pop_legal", int'(bus.pop), 0);
          chk(v == int'(active_vc), "pop_vc", v, int'(active_vc));
          if (pred_en) begin
            if (pred_q.size() == 0) chk(1'b0, "pred_extra_pop", v, -1);
            else begin
              int pv;
              pv = pred_q.pop_front();
              chk(v == pv, "grant_order", v, pv);
            end
          end
          if (vcq[v].size() > 0) exp_q.push_back('{w: vcq[v][0], c: cyc + 2});
          pop_total++;
          last_pop_vc = v;
          if (v == cur_vc) burst_len++;
          else begin
            last_burst_len = burst_len;
            burst_len      = 1;
            cur_vc         = v;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    bit   hit;
    logic [1:0] av;
    for (int v = 0; v < 4; v++) seq[v] = 8'd0;
    reset = 1'b1; init = 1'b0;
    bus.pause = '0; bus.out_almost_full = 1'b0; bus.out_full = 1'b0;
    repeat (3) tick();
    chk(bus.pop == '0, "rst_pop", int'(bus.pop), 0);
    chk(bus.push == 1'b0, "rst_push", int'(bus.push), 0);
    chk(bus.data_out == '0, "rst_data_out", int'(bus.data_out), 0);
    chk(active_vc == 2'd0, "rst_active_vc", int'(active_vc), 0);
    chk(idle == 1'b1, "rst_idle", int'(idle), 1);
    chk(error == 1'b0, "rst_error", int'(error), 0);
    reset = 1'b0;
    tick();

    // Four full VCs: strict 0,1,2,3 rotation in bursts of MB.
    build_pred(10, 10, 10, 10, 3);
    pred_en = 1'b1;
    for (int v = 0; v < 4; v++) load(v, 10);
    wait_drain(400, "t1_drain");
    pred_en = 1'b0;
    chk(pred_q.size() == 0, "t1_pops_left", pred_q.size(), 0);

    // Lone VC2 with three words.
    build_pred(0, 0, 3, 0, 3);
    pred_en = 1'b1;
    n = push_total;
    load(2, 3);
    repeat (2) tick();
    wait_drain(100, "t2_drain");
    pred_en = 1'b0;
    chk(push_total - n == 3, "t2_push_count", push_total - n, 3);
    chk(pred_q.size() == 0, "t2_pops_left", pred_q.size(), 0);
    chk(active_vc == 2'd2, "t2_active_vc", int'(active_vc), 2);

    // Pause VC1 in the middle of its burst.
    for (int v = 0; v < 4; v++) load(v, 20);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (bus.pop[1]) hit = 1'b1;
    end
    chk(hit, "t3_vc1_pop_seen", int'(hit), 1);
    bus.pause[1] = 1'b1;
    #1;
    chk(bus.pop[1] == 1'b0, "t3_pause_same_cycle", int'(bus.pop[1]), 0);
    n = pop_total;
    for (int i = 0; i < 20 && pop_total == n; i++) tick();
    chk(last_pop_vc == 2, "t3_next_vc", last_pop_vc, 2);
    repeat (30) tick();
    bus.pause[1] = 1'b0;
    wait_drain(400, "t3_drain");

    // Almost-full stall mid-burst.
    for (int v = 0; v < 4; v++) load(v, 20);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (bus.pop != '0 && int'(active_vc) != cur_vc) hit = 1'b1;
    end
    chk(hit, "t4_burst_start", int'(hit), 1);
    tick();
    bus.out_almost_full = 1'b1;
    av = active_vc;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk(bus.pop == '0, "t4_stall_pop", int'(bus.pop), 0);
      chk(active_vc == av, "t4_stall_vc", int'(active_vc), int'(av));
      tick();
    end
    bus.out_almost_full = 1'b0;
    for (int i = 0; i < 30 && cur_vc == int'(av); i++) tick();
    chk(last_burst_len == MB, "t4_burst_len", last_burst_len, MB);
    wait_drain(400, "t4_drain");

    // Push into a full output FIFO, then init.
    for (int v = 0; v < 4; v++) load(v, 8);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (bus.push) hit = 1'b1;
    end
    chk(hit, "t5_push_seen", int'(hit), 1);
    bus.out_full = 1'b1;
    tick();
    bus.out_full = 1'b0;
    tick();
    chk(error == 1'b1, "t5_error_set", int'(error), 1);
    repeat (4) tick();
    chk(error == 1'b1, "t5_error_sticky", int'(error), 1);
    init = 1'b1;
    tick();
    init = 1'b0;
    #1;
    chk(bus.push == 1'b0, "t5_init_push", int'(bus.push), 0);
    chk(error == 1'b0, "t5_init_error", int'(error), 0);
    chk(idle == 1'b1, "t5_init_idle", int'(idle), 1);
    wait_drain(400, "t5_drain");

    // Async reset with a word between pop and push.
    load(1, 6);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      tick();
      if (bus.pop != '0) hit = 1'b1;
    end
    chk(hit, "t6_pop_seen", int'(hit), 1);
    tick();
    #1 reset = 1'b1;
    #1;
    chk(bus.push == 1'b0, "t6_rst_push", int'(bus.push), 0);
    chk(bus.pop == '0, "t6_rst_pop", int'(bus.pop), 0);
    chk(idle == 1'b1, "t6_rst_idle", int'(idle), 1);
    chk(active_vc == 2'd0, "t6_rst_active_vc", int'(active_vc), 0);
    chk(bus.data_out == '0, "t6_rst_data_out", int'(bus.data_out), 0);
    chk(error == 1'b0, "t6_rst_error", int'(error), 0);
    repeat (2) tick();
    reset = 1'b0;
    wait_drain(200, "t6_drain");

`ifdef ARB_GRANT_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(grant_cnt == 32'd0, "gcnt_reset", int'(grant_cnt), 0);
    load(0, 300 * MB);
    wait_drain(2500, "gcnt_drain");
    chk(grant_cnt[7:0] == 8'd255, "gcnt_saturate", int'(grant_cnt[7:0]), 255);
    chk(grant_cnt[31:8] == 24'd0, "gcnt_others", int'(grant_cnt[31:8]), 0);
`endif

    // Randomized pause / almost-full traffic.
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(3) == 0) load($urandom_range(3), $urandom_range(1, 3));
      for (int v = 0; v < 4; v++) bus.pause[v] = ($urandom_range(3) == 0);
      bus.out_almost_full = ($urandom_range(5) == 0);
    end
    bus.pause = '0;
    bus.out_almost_full = 1'b0;
    wait_drain(800, "rand_drain");
    chk(exp_q.size() == 0, "final_scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
